ioblock_deser: RTL and testbench
================================

Name: ioblock_deser

Overview:
- Input deserializer that sits directly downstream of an I/O block's IN output.
- Samples the serial IN bit on every enabled IOCLK edge and assembles WIDTH-bit words, LSB first.
- Supports a BITSLIP word-boundary adjustment.
- Delivers words to fabric logic through a 2-entry valid/ready output buffer with sticky overrun reporting.

Parameters:
WIDTH, 8, deserialized word width in bits; legal range 2..32.
SYNC_WORD, 8'hA5, WIDTH-bit alignment pattern; used only when IOBLOCK_DESER_SYNC_EN is defined.

Ports:
IOCLK  input  1  single clock; all state updates on its rising edge.
RST  input  1  synchronous, active-high reset; sampled on the IOCLK rising edge.
CE  input  1  bit-sample enable; IN_BIT is ignored when 0.
IN_BIT  input  1  serial data, connected to the I/O block IN output.
BITSLIP  input  1  drop-one-bit request, qualified by CE.
WORD  output  WIDTH  head entry of the output buffer.
WORD_VALID  output  1  output buffer non-empty.
WORD_READY  input  1  consumer accepts WORD when WORD_VALID && WORD_READY.
OVERRUN  output  1  sticky: at least one completed word was dropped.
LOCKED  output  1  word alignment achieved.

Behaviour:
- Reset (RST=1 at an edge): shift register = 0, bit counter cnt = 0, buffer empty. Outputs: WORD = 0, WORD_VALID = 0, OVERRUN = 0. LOCKED = 0 if IOBLOCK_DESER_SYNC_EN is defined, else 1. RST overrides every other input in the same cycle; a partially assembled word is discarded.
- Shift (CE=1, BITSLIP=0): sr <= {IN_BIT, sr[WIDTH-1:1]}; cnt <= cnt+1.
- Word complete: when cnt == WIDTH-1 on a shift, the word {IN_BIT, sr[WIDTH-1:1]} is pushed into the buffer at that same edge and cnt <= 0. WORD_VALID is high after that edge (latency: 1 edge from the final bit's sample).
- Bitslip (CE=1, BITSLIP=1): the sampled bit is discarded; sr and cnt are unchanged. Net effect: the boundary moves one bit later.
- BITSLIP with CE=0: no effect.
- Consecutive BITSLIP cycles each drop one bit.
- CE=0 with no slip: sr and cnt hold. The buffer still pops normally.
- Buffer: 2 entries, FIFO order.
  - Pop on WORD_VALID && WORD_READY.
  - WORD always shows the head entry and holds its value while WORD_VALID && !WORD_READY.
  - When the buffer empties, WORD keeps the last popped value; consumers qualify WORD with WORD_VALID.
- Full and push, no pop in the same cycle: the new word is dropped, buffer contents are unchanged, OVERRUN <= 1 and stays 1 until RST.
- Full with simultaneous push and pop: the head pops, the new word is written; no overrun.
- Empty with simultaneous push and WORD_READY=1: no pop that cycle (WORD_VALID was 0); the word appears next cycle.
- cnt wraps only via word completion; it never exceeds WIDTH-1.

Optional Feature:
- Macro: IOBLOCK_DESER_SYNC_EN.
- Defined: two-state FSM, HUNT and LOCKED; HUNT after reset.
  - In HUNT, on each CE=1 cycle the window {IN_BIT, sr[WIDTH-1:1]} is compared with SYNC_WORD. The window includes the current bit, so a match is possible only once WIDTH bits have been shifted since reset.
  - On a match: state <= LOCKED, LOCKED <= 1, cnt <= 0. The sync word itself is not pushed.
  - In HUNT: no words are pushed, BITSLIP is ignored, sr keeps shifting and cnt stays 0.
  - LOCKED behaves as normal deserialization and leaves only on RST.
- Undefined: no FSM; LOCKED is tied to 1 and deserialization starts immediately after reset.

Test Plan:
- Reset then CE=1 with IN_BIT sequence 1,0,1,0,0,1,0,1 (no sync macro), WORD_READY=1 -> after the 8th edge WORD = 8'hA5 and WORD_VALID=1 for exactly 1 cycle; OVERRUN=0.
- Stream of bits forming words 8'h01, 8'h02, 8'h03 with WORD_READY=0 -> buffer holds 8'h01 then 8'h02; 8'h03 dropped; OVERRUN=1. Raise WORD_READY -> 8'h01 then 8'h02 delivered; WORD_VALID then low; OVERRUN still 1 until RST.
- Buffer full with WORD_READY=1 in the cycle the next word completes -> no drop; order preserved; OVERRUN=0.
- One BITSLIP pulse with CE=1 before a 0x00 bit and then the stream 0xA5 LSB-first -> WORD = 8'hA5 (the dropped leading bit realigns the boundary). BITSLIP with CE=0 -> no change.
- IOBLOCK_DESER_SYNC_EN defined: 3 garbage bits, then SYNC_WORD 8'hA5, then 8'h3C -> LOCKED rises on the edge of the last sync bit; the only word delivered is 8'h3C.
- RST asserted mid-word after 5 bits, then a fresh 8-bit word -> partial bits discarded; first WORD equals the fresh word; LOCKED returns to 0 when the macro is defined.

Source files
------------

// File: rtl/ioblock_deser.sv
// Serial-to-parallel input deserializer with bitslip and a 2-entry valid/ready output buffer.
// Optional sync-word alignment FSM enabled by defining IOBLOCK_DESER_SYNC_EN.
module ioblock_deser #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(8'hA5)
) (
    input  logic             IOCLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             IN_BIT,
    input  logic             BITSLIP,
    output logic [WIDTH-1:0] WORD,
    output logic             WORD_VALID,
    input  logic             WORD_READY,
    output logic             OVERRUN,
    output logic             LOCKED
);
    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    // Only the upper WIDTH-1 bits of the shift register are ever read back.
    logic [WIDTH-2:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] tail;
    logic [1:0]       fill;
    logic [WIDTH-1:0] window;
    logic             hunting;
    logic             shift_en;
    logic             push;
    logic             pop;

`ifdef IOBLOCK_DESER_SYNC_EN
    typedef enum logic {HUNT, LOCK} state_t;
    state_t state;
    assign hunting = (state == HUNT);
`else
    logic unused_sync;
    assign unused_sync = ^SYNC_WORD;
    assign hunting     = 1'b0;
`endif

    assign window     = {IN_BIT, sr};
    assign WORD_VALID = (fill != 2'd0);
    assign pop        = WORD_VALID && WORD_READY;

    // While hunting, bitslip is ignored so the sync search sees every bit.
    always_comb begin
        shift_en = CE && (hunting || !BITSLIP);
        push     = CE && !BITSLIP && !hunting && (cnt == LAST);
    end

    always_ff @(posedge IOCLK) begin
        if (RST) begin
            sr      <= '0;
            cnt     <= '0;
            WORD    <= '0;
            tail    <= '0;
            fill    <= 2'd0;
            OVERRUN <= 1'b0;
`ifdef IOBLOCK_DESER_SYNC_EN
            state   <= HUNT;
            LOCKED  <= 1'b0;
`else
            LOCKED  <= 1'b1;
`endif
        end else begin
            if (shift_en)
                sr <= window[WIDTH-1:1];

`ifdef IOBLOCK_DESER_SYNC_EN
            if (hunting) begin
                if (CE && window == SYNC_WORD) begin
                    state  <= LOCK;
                    LOCKED <= 1'b1;
                end
            end else
`endif
            if (CE && !BITSLIP)
                cnt <= push ? '0 : cnt + CW'(1);

            // Head shifts forward only when a second entry exists; an empty
            // buffer leaves WORD at the last popped value.
            if (pop && fill == 2'd2)
                WORD <= tail;

            if (push) begin
                case (fill)
                    2'd0: begin
                        WORD <= window;
                        fill <= 2'd1;
                    end
                    2'd1: begin
                        if (pop) begin
                            WORD <= window;
                        end else begin
                            tail <= window;
                            fill <= 2'd2;
                        end
                    end
                    default: begin
                        if (pop)
                            tail <= window;
                        else
                            OVERRUN <= 1'b1;
                    end
                endcase
            end else if (pop) begin
                fill <= fill - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_ioblock_deser.sv
// Directed self-checking bench for ioblock_deser (WIDTH=8); covers both sync-macro builds.
module tb_ioblock_deser;
    logic       IOCLK = 1'b0;
    logic       RST = 1'b1;
    logic       CE = 1'b0;
    logic       IN_BIT = 1'b0;
    logic       BITSLIP = 1'b0;
    logic       WORD_READY = 1'b0;
    logic [7:0] WORD;
    logic       WORD_VALID;
    logic       OVERRUN;
    logic       LOCKED;

    int tests = 0;
    int fails = 0;

`ifdef IOBLOCK_DESER_SYNC_EN
    localparam logic LOCK_AFTER_RST = 1'b0;
`else
    localparam logic LOCK_AFTER_RST = 1'b1;
`endif

    ioblock_deser #(.WIDTH(8), .SYNC_WORD(8'hA5)) dut (
        .IOCLK(IOCLK), .RST(RST), .CE(CE), .IN_BIT(IN_BIT), .BITSLIP(BITSLIP),
        .WORD(WORD), .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY),
        .OVERRUN(OVERRUN), .LOCKED(LOCKED)
    );

    always #5 IOCLK = ~IOCLK;

    task automatic step();
        @(posedge IOCLK);
        @(negedge IOCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic slip);
        CE = 1'b1; IN_BIT = b; BITSLIP = slip;
        step();
        CE = 1'b0; BITSLIP = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i], 1'b0);
    endtask

    // Reset with data inputs active to show RST dominates.
    task automatic do_reset();
        RST = 1'b1; CE = 1'b1; IN_BIT = 1'b1; BITSLIP = 1'b0;
        step();
        RST = 1'b0; CE = 1'b0; IN_BIT = 1'b0;
    endtask

    // In the sync build, data words only flow after the alignment pattern.
    task automatic lock_up();
`ifdef IOBLOCK_DESER_SYNC_EN
        send_word(8'hA5);
`endif
    endtask

    initial begin
        logic [7:0] w;
        @(negedge IOCLK);

        // Reset state
        do_reset();
        chk("rst_word",    {24'd0, WORD}, 32'h00);
        chk("rst_valid",   {31'd0, WORD_VALID}, 32'd0);
        chk("rst_overrun", {31'd0, OVERRUN}, 32'd0);
        chk("rst_locked",  {31'd0, LOCKED}, {31'd0, LOCK_AFTER_RST});
        lock_up();

        // Basic word, ready high on completion: visible for exactly one cycle
        WORD_READY = 1'b1;
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(0, 0);
        send_bit(0, 0); send_bit(1, 0); send_bit(0, 0);
        chk("t1_pre_valid", {31'd0, WORD_VALID}, 32'd0);
        send_bit(1, 0);
        chk("t1_word",  {24'd0, WORD}, 32'hA5);
        chk("t1_valid", {31'd0, WORD_VALID}, 32'd1);
        step();
        chk("t1_valid_drop", {31'd0, WORD_VALID}, 32'd0);
        chk("t1_word_hold",  {24'd0, WORD}, 32'hA5);
        chk("t1_overrun",    {31'd0, OVERRUN}, 32'd0);

        // Overrun: third word dropped while the buffer is full
        WORD_READY = 1'b0;
        send_word(8'h01);
        send_word(8'h02);
        chk("t2_no_ovr_yet", {31'd0, OVERRUN}, 32'd0);
        send_word(8'h03);
        chk("t2_head",    {24'd0, WORD}, 32'h01);
        chk("t2_valid",   {31'd0, WORD_VALID}, 32'd1);
        chk("t2_overrun", {31'd0, OVERRUN}, 32'd1);
        step();
        chk("t2_hold", {24'd0, WORD}, 32'h01);
        WORD_READY = 1'b1;
        step();
        chk("t2_second",  {24'd0, WORD}, 32'h02);
        chk("t2_valid2",  {31'd0, WORD_VALID}, 32'd1);
        step();
        chk("t2_empty",   {31'd0, WORD_VALID}, 32'd0);
        chk("t2_last",    {24'd0, WORD}, 32'h02);
        chk("t2_sticky",  {31'd0, OVERRUN}, 32'd1);
        do_reset();
        chk("t2_ovr_clr", {31'd0, OVERRUN}, 32'd0);
        lock_up();

        // Full buffer, pop coincides with the next push: nothing lost
        WORD_READY = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        w = 8'h33;
        for (int i = 0; i < 7; i++) send_bit(w[i], 0);
        WORD_READY = 1'b1;
        send_bit(w[7], 0);
        chk("t3_head",    {24'd0, WORD}, 32'h22);
        chk("t3_overrun", {31'd0, OVERRUN}, 32'd0);
        step();
        chk("t3_next",  {24'd0, WORD}, 32'h33);
        chk("t3_valid", {31'd0, WORD_VALID}, 32'd1);
        step();
        chk("t3_empty", {31'd0, WORD_VALID}, 32'd0);
        chk("t3_ovr",   {31'd0, OVERRUN}, 32'd0);

        // Bitslip drops one leading bit
        WORD_READY = 1'b0;
        send_bit(0, 1);
        send_word(8'hA5);
        chk("t4_slip", {24'd0, WORD}, 32'hA5);
        chk("t4_slip_valid", {31'd0, WORD_VALID}, 32'd1);
        WORD_READY = 1'b1;
        step();
        WORD_READY = 1'b0;
        // Bitslip without CE does nothing
        BITSLIP = 1'b1; IN_BIT = 1'b1;
        step();
        BITSLIP = 1'b0;
        send_word(8'h3C);
        chk("t4_noce_slip", {24'd0, WORD}, 32'h3C);
        WORD_READY = 1'b1;
        step();
        WORD_READY = 1'b0;
        // Two consecutive slips drop two bits
        send_bit(1, 1);
        send_bit(1, 1);
        send_word(8'h5A);
        chk("t4_double_slip", {24'd0, WORD}, 32'h5A);
        WORD_READY = 1'b1;
        step();

`ifdef IOBLOCK_DESER_SYNC_EN
        // Hunt for sync after garbage; only the following word is delivered
        do_reset();
        WORD_READY = 1'b0;
        send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
        w = 8'hA5;
        for (int i = 0; i < 7; i++) send_bit(w[i], 0);
        chk("t5_not_locked", {31'd0, LOCKED}, 32'd0);
        send_bit(w[7], 0);
        chk("t5_locked",   {31'd0, LOCKED}, 32'd1);
        chk("t5_no_word",  {31'd0, WORD_VALID}, 32'd0);
        send_word(8'h3C);
        chk("t5_word",  {24'd0, WORD}, 32'h3C);
        WORD_READY = 1'b1;
        step();
        chk("t5_only",  {31'd0, WORD_VALID}, 32'd0);
`endif

        // Reset mid-word discards the partial bits
        WORD_READY = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1, 0);
        do_reset();
        chk("t6_locked", {31'd0, LOCKED}, {31'd0, LOCK_AFTER_RST});
        chk("t6_valid",  {31'd0, WORD_VALID}, 32'd0);
        lock_up();
        send_word(8'hC3);
        chk("t6_word",   {24'd0, WORD}, 32'hC3);
        chk("t6_valid2", {31'd0, WORD_VALID}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
